// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the integer register-file write path.
//   NREGS, AW, DW : register count, address width, data width
//   state_t       : write-controller FSM states (CLEAR, RUN)
//   wr_req_t      : one register-file write request {addr, data}; also used by
//                   the WB stage
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_aux_fifo.sv
// -----------------------------------------------------------------------------
// regfile_aux_fifo
// Synchronous FIFO of wr_req_t used to park auxiliary write requests until the
// register-file write port is free. DEPTH must be a power of two, >= 2.
//   clk, rst     : clock, asynchronous active-high reset (flushes the FIFO)
//   push, wdata  : enqueue wdata when push is high and the FIFO is not full
//   pop          : dequeue the head when pop is high and the FIFO is not empty
//   head         : current head entry (valid when empty is low)
//   full, empty  : occupancy flags
// -----------------------------------------------------------------------------
module regfile_aux_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wr_req_t wdata,
  input  logic    pop,
  output wr_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int PW = $clog2(DEPTH);

  wr_req_t       mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[PW-1:0]];

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are valid, so clearing the data would only cost reset routing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/regfile_write_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_write_ctrl
// Owner of the single register-file write port. Arbitrates between the WB stage
// (never back-pressured, highest priority) and a queued auxiliary requester
// (valid/ready). Writes to x0 are dropped. An aux head that keeps losing to WB
// for STARVE_MAX cycles raises stall_req so the pipeline can leave a gap.
//
// Build option REGFILE_CLEAR_EN: when defined, reset enters a CLEAR state that
// writes zero to every register (one per cycle) before normal operation. When
// undefined the controller resets straight into RUN and init_busy is tied low.
//
// Ports
//   clk, rst                    : clock, asynchronous active-high reset
//   wb_valid, wb_addr, wb_data  : writeback request, always accepted
//   aux_valid, aux_addr,
//   aux_data, aux_ready         : auxiliary request with valid/ready handshake
//   rf_we, rf_waddr, rf_wdata   : registered register-file write port
//   init_busy                   : clear sequence in progress
//   stall_req                   : ask the pipeline to hold WB next cycle
// -----------------------------------------------------------------------------
module regfile_write_ctrl
  import regfile_pkg::*;
#(
  parameter int Q_DEPTH    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          aux_valid,
  output logic          aux_ready,
  input  logic [AW-1:0] aux_addr,
  input  logic [DW-1:0] aux_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          init_busy,
  output logic          stall_req
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);

  state_t        state;
  state_t        state_next;
  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_next;
  logic          we_next;
  logic [AW-1:0] waddr_next;
  logic [DW-1:0] wdata_next;
  logic          stall_next;
  logic          wb_hit;
  logic          q_push;
  logic          q_pop;
  logic          q_full;
  logic          q_empty;
  wr_req_t       q_head;
  wr_req_t       q_wdata;

`ifdef REGFILE_CLEAR_EN
  logic [AW-1:0] clr_cnt;
`endif

  // ---------------------------------------------------------------------------
  // Auxiliary request queue
  // ---------------------------------------------------------------------------
`ifdef REGFILE_CLEAR_EN
  assign aux_ready = (state == RUN) && !q_full;
  assign init_busy = (state == CLEAR);
`else
  // Without a clear phase the FSM sits in RUN during reset, so reset itself
  // has to hold aux_ready low.
  assign aux_ready = (state == RUN) && !q_full && !rst;
  assign init_busy = 1'b0;
`endif

  assign q_push        = aux_valid && aux_ready;
  assign q_wdata.addr  = aux_addr;
  assign q_wdata.data  = aux_data;

  regfile_aux_fifo #(
    .DEPTH (Q_DEPTH)
  ) u_aux_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .wdata (q_wdata),
    .pop   (q_pop),
    .head  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  // ---------------------------------------------------------------------------
  // Next-state, arbitration and starvation tracking
  // ---------------------------------------------------------------------------
  assign wb_hit = wb_valid && (wb_addr != '0);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    we_next     = 1'b0;
    waddr_next  = rf_waddr;
    wdata_next  = rf_wdata;
    q_pop       = 1'b0;
    starve_next = '0;
    stall_next  = 1'b0;

    unique case (state)
      CLEAR: begin
`ifdef REGFILE_CLEAR_EN
        we_next    = 1'b1;
        waddr_next = clr_cnt;
        wdata_next = '0;
        stall_next = 1'b1;
        if (clr_cnt == AW'(NREGS - 1)) begin
          state_next = RUN;
          stall_next = 1'b0;
        end
`else
        state_next = RUN;
`endif
      end

      RUN: begin
        if (wb_hit) begin
          we_next    = 1'b1;
          waddr_next = wb_addr;
          wdata_next = wb_data;
        end else if (!q_empty) begin
          // An x0 head is popped silently.
          q_pop = 1'b1;
          if (q_head.addr != '0) begin
            we_next    = 1'b1;
            waddr_next = q_head.addr;
            wdata_next = q_head.data;
          end
        end

        // Head waiting but not granted: keep counting (saturating); stall
        // once the counter has already sat at its ceiling for a cycle.
        if (!q_empty && !q_pop) begin
          starve_next = (starve_cnt == STARVE_SAT) ? starve_cnt
                                                   : starve_cnt + 1'b1;
          stall_next  = (starve_cnt == STARVE_SAT);
        end
      end

      default: state_next = RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef REGFILE_CLEAR_EN
      state     <= CLEAR;
      stall_req <= 1'b1;
`else
      state     <= RUN;
      stall_req <= 1'b0;
`endif
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      stall_req  <= stall_next;
      rf_we      <= we_next;
      rf_waddr   <= waddr_next;
      rf_wdata   <= wdata_next;
      starve_cnt <= starve_next;
    end
  end

`ifdef REGFILE_CLEAR_EN
  // Clear address; wraps to 0 after NREGS-1, ready for the next reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_ctrl
// Directed plus randomized stimulus for regfile_write_ctrl, compared every
// cycle against a transaction-level reference model (a request queue and a
// few counters). Works with and without REGFILE_CLEAR_EN.
// -----------------------------------------------------------------------------
module tb_regfile_write_ctrl;
  import regfile_pkg::*;

  localparam int Q_DEPTH    = 2;
  localparam int STARVE_MAX = 4;
`ifdef REGFILE_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          aux_valid;
  logic          aux_ready;
  logic [AW-1:0] aux_addr;
  logic [DW-1:0] aux_data;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          init_busy;
  logic          stall_req;

  regfile_write_ctrl #(
    .Q_DEPTH    (Q_DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .aux_valid (aux_valid),
    .aux_ready (aux_ready),
    .aux_addr  (aux_addr),
    .aux_data  (aux_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .init_busy (init_busy),
    .stall_req (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit            m_clear;
  int            m_cnt;
  wr_req_t       m_q[$];
  int            m_starve;
  bit            e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  bit            e_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_bad++;
    $error("FAIL %s: observed=timeout expected=event", tag);
  endtask

  task automatic model_reset();
    m_clear  = CLR_EN;
    m_cnt    = 0;
    m_q.delete();
    m_starve = 0;
    e_we     = 1'b0;
    e_addr   = '0;
    e_data   = '0;
    e_stall  = CLR_EN;
  endtask

  function automatic bit model_ready();
    return !m_clear && (m_q.size() < Q_DEPTH);
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_edge();
    bit      rdy;
    bit      had;
    bit      granted;
    wr_req_t h;
    wr_req_t r;
    rdy = model_ready();
    if (m_clear) begin
      e_we   = 1'b1;
      e_addr = AW'(m_cnt);
      e_data = '0;
      m_cnt++;
      if (m_cnt == NREGS) begin
        m_clear = 1'b0;
        m_cnt   = 0;
      end
      e_stall = m_clear;
    end else begin
      had     = (m_q.size() > 0);
      granted = 1'b0;
      e_we    = 1'b0;
      if (wb_valid && wb_addr != 0) begin
        e_we   = 1'b1;
        e_addr = wb_addr;
        e_data = wb_data;
      end else if (had) begin
        h       = m_q.pop_front();
        granted = 1'b1;
        if (h.addr != 0) begin
          e_we   = 1'b1;
          e_addr = h.addr;
          e_data = h.data;
        end
      end
      if (had && !granted) begin
        e_stall = (m_starve == STARVE_MAX);
        if (m_starve < STARVE_MAX) m_starve++;
      end else begin
        e_stall  = 1'b0;
        m_starve = 0;
      end
    end
    if (aux_valid && rdy) begin
      r.addr = aux_addr;
      r.data = aux_data;
      m_q.push_back(r);
    end
  endtask

  // One clock: drive inputs, check the handshake, clock, check the write port.
  task automatic step(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      output bit acc);
    wb_valid  = wv;
    wb_addr   = wa;
    wb_data   = wd;
    aux_valid = av;
    aux_addr  = aa;
    aux_data  = ad;
    #1;
    acc = av && model_ready();
    chk("aux_ready", aux_ready, model_ready());
    chk("init_busy", init_busy, m_clear);
    model_edge();
    @(posedge clk);
    #1;
    chk("rf_we", rf_we, e_we);
    if (e_we) begin
      chk("rf_waddr", rf_waddr, e_addr);
      chk("rf_wdata", rf_wdata, e_data);
    end
    chk("stall_req", stall_req, e_stall);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, acc);
  endtask

  task automatic check_reset_values();
    chk("rst_rf_we",     rf_we,     1'b0);
    chk("rst_rf_waddr",  rf_waddr,  '0);
    chk("rst_rf_wdata",  rf_wdata,  '0);
    chk("rst_aux_ready", aux_ready, 1'b0);
    chk("rst_init_busy", init_busy, CLR_EN);
    chk("rst_stall_req", stall_req, CLR_EN);
  endtask

  initial begin
    bit acc;
    int tries;
    rst       = 1'b1;
    wb_valid  = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    aux_valid = 1'b0;
    aux_addr  = '0;
    aux_data  = '0;
    model_reset();
    #2;
    check_reset_values();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Clear sequence (or plain idle cycles without the clear phase)
    idle(NREGS);
    chk("clear_done_ready", aux_ready, 1'b1);
    chk("clear_done_busy",  init_busy, 1'b0);
    idle(2);

    // WB priority over a simultaneous aux request
    step(1, 5'd5, 32'hAA, 1, 5'd6, 32'hBB, acc);
    chk("prio_wb_addr", rf_waddr, 5'd5);
    step(0, '0, '0, 0, '0, '0, acc);
    chk("prio_aux_addr", rf_waddr, 5'd6);
    chk("prio_aux_data", rf_wdata, 32'hBB);

    // x0 drop: queue an aux write behind WB, then WB targets x0
    step(1, 5'd9, 32'h99, 1, 5'd7, 32'hCC, acc);
    step(1, 5'd0, 32'h1234, 0, '0, '0, acc);
    chk("x0_aux_wins", rf_waddr, 5'd7);
    // aux entry to x0 is popped with no write
    step(1, 5'd10, 32'h10, 1, 5'd0, 32'hDEAD, acc);
    step(0, '0, '0, 0, '0, '0, acc);
    chk("x0_aux_dropped", rf_we, 1'b0);
    idle(1);

    // Queue full: two requests accepted while WB is busy, third is held
    step(1, 5'd1, 32'h101, 1, 5'd11, 32'h111, acc);
    step(1, 5'd2, 32'h102, 1, 5'd12, 32'h112, acc);
    chk("full_ready_low", aux_ready, 1'b0);
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 10) begin
      step(tries < 3, 5'd3, 32'h103, 1, 5'd13, 32'h113, acc);
      tries++;
    end
    if (!acc) timeout("full_third_accept");
    idle(4);

    // Starvation: one queued entry, WB hogs the port
    step(1, 5'd4, 32'h200, 1, 5'd14, 32'h214, acc);
    for (int i = 0; i < 7; i++) step(1, AW'(20 + i), DW'(32'h300 + i), 0, '0, '0, acc);
    chk("starve_stall_high", stall_req, 1'b1);
    step(0, '0, '0, 0, '0, '0, acc);
    chk("starve_head_write", rf_waddr, 5'd14);
    step(0, '0, '0, 0, '0, '0, acc);
    chk("starve_stall_clear", stall_req, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 45),
           ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom),
           DW'($urandom),
           ($urandom_range(0, 99) < 50),
           ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom),
           DW'($urandom), acc);
    end
    idle(4);

    // Mid-operation reset with two entries queued
    step(1, 5'd1, 32'h501, 1, 5'd15, 32'h515, acc);
    step(1, 5'd2, 32'h502, 1, 5'd16, 32'h516, acc);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(NREGS + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/regfile_write_ctrl.md
# regfile_write_ctrl

Write-port controller for the 32×32 integer register file. Owns the single register-file write port and multiplexes it between the pipeline writeback stage, which is never back-pressured, and an auxiliary requester such as a debug port or multi-cycle unit, which uses a valid/ready handshake. Out of reset it runs a clear sequence that zeroes every register. It sits between the WB stage and the register file, and drives the file's RegWrite, w_add and RegWriteData inputs.

## Interface
- NREGS, 32, number of architectural registers
- AW, 5, register address width
- DW, 32, data width
- Q_DEPTH, 2, auxiliary queue depth (power of two, ≥2)
- STARVE_MAX, 4, cycles a queued aux write may wait before a stall is requested
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- wb_valid  in  1  writeback write request, always accepted
- wb_addr  in  AW  writeback destination
- wb_data  in  DW  writeback data
- aux_valid  in  1  aux write request
- aux_ready  out  1  aux request accepted this cycle when high with aux_valid
- aux_addr  in  AW  aux destination
- aux_data  in  DW  aux data
- rf_we  out  1  register-file write enable
- rf_waddr  out  AW  register-file write address
- rf_wdata  out  DW  register-file write data
- init_busy  out  1  clear sequence in progress
- stall_req  out  1  request to the pipeline to hold WB (wb_valid low) next cycle

## Operation
- The FSM has two states, CLEAR and RUN.
- On rst the FSM enters CLEAR, and the clear counter resets to 0.
- **CLEAR**
  - Each cycle writes 0 to address cnt and increments cnt.
  - After writing address NREGS-1, the FSM moves to RUN.
  - wb_valid is ignored, aux_ready=0, and stall_req=1.
- **RUN arbitration** (fixed priority):
  - A wb write with wb_addr≠0 wins the port.
  - Otherwise the aux queue head is written, if the queue is non-empty.
  - Otherwise rf_we=0 next cycle.
- **Address 0:** writes to address 0 are dropped from either source and never assert rf_we. An aux entry to x0 is popped without a write.
- **Aux queue**
  - FIFO of Q_DEPTH entries.
  - aux_ready = (state==RUN) && !full.
  - A push and a pop in the same cycle are legal when the queue is not full.
  - Aux order is preserved. Ordering between the wb and aux streams is not enforced.
- **Starvation**
  - starve_cnt counts cycles in which the queue is non-empty and the head is not granted. It saturates at STARVE_MAX.
  - stall_req is set when starve_cnt==STARVE_MAX.
  - stall_req clears when the head is granted or the queue is empty.
  - If wb_valid is asserted despite stall_req, wb still wins. There is no error output.

## Timing
- rf_we, rf_waddr and rf_wdata are registered: one cycle of latency from a wb request or from a queue pop.
- **Reset values:**
  - rf_we=0, rf_waddr=0, rf_wdata=0, aux_ready=0.
  - init_busy=1 and stall_req=1 with REGFILE_CLEAR_EN; 0 and 0 without it.
  - Queue empty, starve_cnt=0.
- The clear sequence takes NREGS cycles, writing addresses 0..31.
- init_busy falls in the same cycle that aux_ready may first rise.
- Best case for an aux write: it is accepted in cycle t, popped in cycle t+1 when WB is idle, and rf_we is high in cycle t+2.
- stall_req is registered. It is asserted at the earliest STARVE_MAX+1 cycles after the head first becomes blocked.
- **rst asserted mid-operation:** the queue is flushed, in-flight writes are lost, and the FSM re-enters CLEAR immediately (asynchronous).

## Configuration
- The macro is REGFILE_CLEAR_EN.
- **Defined:** the CLEAR state and counter exist, and the timing is as above.
- **Undefined:**
  - The FSM resets directly into RUN, and the clear counter is removed.
  - init_busy is tied to 0.
  - aux_ready may be 1 in the first cycle after rst falls.
  - Register contents after reset are whatever the register file initialises them to.

## Structure
- Package regfile_pkg holds:
  - NREGS, AW, DW constants.
  - The state enum {CLEAR, RUN}.
  - A packed wr_req_t struct {addr, data}, shared with the WB stage.
- One sub-module, regfile_aux_fifo: a synchronous Q_DEPTH FIFO of wr_req_t with full/empty flags and asynchronous active-high reset.
- The arbiter, FSM and starvation counter stay in the top module.

## Test plan
- **Clear sequence:** release rst and hold it low for 32 cycles. rf_we=1 with rf_waddr stepping 0..31 and rf_wdata=0, init_busy falls, and aux_ready=1 in cycle 32.
- **WB priority:** in the same cycle present wb_valid (addr 5, data 0xAA) and aux (addr 6, data 0xBB). Next cycle is a write to 5=0xAA; the cycle after is a write to 6=0xBB.
- **x0 drop:** wb_valid with addr 0 and data 0x1234. rf_we stays 0; a pending aux head is written that cycle instead.
- **Queue full:** push 2 aux requests while wb_valid is held high. aux_ready=0 on the third request and the request is held without loss. Drain order is preserved.
- **Starvation:** queue one aux request and hold wb_valid to nonzero addresses. stall_req rises after 5 cycles; drop wb_valid, the aux write occurs, and stall_req clears.
- **Mid-operation reset:** assert rst with 2 entries queued. Outputs reach their reset values asynchronously, the queue is empty after release, and the clear sequence restarts at address 0.
